// File: rtl/vip_bin_morph_3x3_pkg.sv
// Shared constants and helpers for the binary 3x3 morphology stage.
package vip_bin_morph_3x3_pkg;

  localparam logic MORPH_DILATE = 1'b0;
  localparam logic MORPH_ERODE  = 1'b1;

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    ACTIVE     = 1'b1
  } morph_state_e;

  function automatic int col_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  // Out-of-frame taps must be neutral for the reduction: 0 for OR, 1 for AND.
  function automatic logic pad_value(input logic mode);
    return (mode == MORPH_ERODE) ? 1'b1 : 1'b0;
  endfunction

  function automatic logic reduce9(input logic mode, input logic [8:0] win);
    return (mode == MORPH_ERODE) ? (&win) : (|win);
  endfunction

endpackage

// File: rtl/vip_bin_linebuf_2row.sv
// Two-row, 1-bit-per-row line RAM: asynchronous read, write at the clock edge,
// so a same-cycle read returns the old contents.
module vip_bin_linebuf_2row
  import vip_bin_morph_3x3_pkg::*;
#(
  parameter  int IMG_WIDTH = 640,
  localparam int COL_W     = col_width(IMG_WIDTH)
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic             mask_i,
  input  logic [COL_W-1:0] addr_i,
  input  logic [1:0]       wdata_i,
  output logic [1:0]       rdata_o
);

  localparam logic [COL_W-1:0] ADDR_MAX = COL_W'(IMG_WIDTH - 1);

  logic [1:0]       mem_q [IMG_WIDTH];
  logic [COL_W-1:0] addr_s;

  always_comb begin
    addr_s = (addr_i > ADDR_MAX) ? ADDR_MAX : addr_i;
  end

  assign rdata_o = mem_q[addr_s];

  // Masked pixels lie past the line end and must not clobber stored rows.
  always_ff @(posedge clk) begin
    if (wr_en_i && !mask_i) begin
      mem_q[addr_s] <= wdata_i;
    end
  end

endmodule

// File: rtl/vip_bin_morph_3x3.sv
// Binary 3x3 dilate/erode on a 1-bit edge stream; sync qualifiers pass through
// a fixed 2-clock pipe and the result is centred one row/column behind the input.
module vip_bin_morph_3x3
  import vip_bin_morph_3x3_pkg::*;
#(
  parameter  int IMG_WIDTH = 640,
  parameter  int MODE      = 0,
  localparam int COL_W     = col_width(IMG_WIDTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic per_frame_vsync,
  input  logic per_frame_href,
  input  logic per_frame_clken,
  input  logic per_img_Bit,
  output logic post_frame_vsync,
  output logic post_frame_href,
  output logic post_frame_clken,
  output logic post_img_Bit
);

  localparam logic             MODE_BIT = (MODE != 0) ? MORPH_ERODE : MORPH_DILATE;
  localparam logic             PAD      = pad_value(MODE_BIT);
  localparam logic [COL_W-1:0] COL_MAX  = COL_W'(IMG_WIDTH - 1);

  morph_state_e     state_q;
  logic             vs_q, href_q, clken_q;
  logic             vs_q2, href_q2, clken_q2;
  logic             bit_q, bit_d;
  logic [COL_W-1:0] col_q, col_d, col_s;
  logic             ovf_q, ovf_d, ovf_s;
  logic [1:0]       row_q, row_d, row_s;
  logic [2:0]       w0_q, w1_q, w2_q, w0_d, w1_d, w2_d;
  logic             vs_rise_s, href_rise_s, href_fall_s, pix_s;
  logic             up1_s, up2_s;
  logic [1:0]       rd_s;

  vip_bin_linebuf_2row #(.IMG_WIDTH(IMG_WIDTH)) u_linebuf (
    .clk     (clk),
    .wr_en_i (pix_s),
    .mask_i  (ovf_s),
    .addr_i  (col_s),
    .wdata_i ({rd_s[0], per_img_Bit}),
    .rdata_o (rd_s)
  );

  // Edge detection and the effective counters seen by the current pixel.
  always_comb begin
    vs_rise_s   = per_frame_vsync & ~vs_q;
    href_rise_s = per_frame_href & ~href_q;
    href_fall_s = ~per_frame_href & href_q;
    pix_s       = per_frame_clken & per_frame_href;
    col_s       = (vs_rise_s | href_rise_s) ? {COL_W{1'b0}} : col_q;
    ovf_s       = (vs_rise_s | href_rise_s) ? 1'b0 : ovf_q;
    row_s       = vs_rise_s ? 2'd0 : row_q;
    up1_s       = ((row_s != 2'd0) && !ovf_s) ? rd_s[0] : PAD;
    up2_s       = ((row_s == 2'd2) && !ovf_s) ? rd_s[1] : PAD;
  end

  // Counters, window shift and reduction; column pads replace stale taps at line start.
  always_comb begin
    col_d = col_s;
    ovf_d = ovf_s;
    w0_d  = w0_q;
    w1_d  = w1_q;
    w2_d  = w2_q;
    if (pix_s) begin
      if (col_s == COL_MAX) begin
        ovf_d = 1'b1;
      end else begin
        col_d = col_s + COL_W'(1'b1);
      end
      w0_d = {up2_s, up1_s, per_img_Bit};
      w1_d = (col_s == {COL_W{1'b0}}) ? {3{PAD}} : w0_q;
      w2_d = (col_s == {COL_W{1'b0}}) ? {3{PAD}} : w1_q;
    end else begin
      col_d = col_s;
    end
    if (vs_rise_s) begin
      row_d = 2'd0;
    end else if (href_fall_s && (row_q != 2'd2)) begin
      row_d = row_q + 2'd1;
    end else begin
      row_d = row_q;
    end
    bit_d = (state_q == ACTIVE) & href_q & reduce9(MODE_BIT, {w2_q, w1_q, w0_q});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q     <= 1'b0;
      href_q   <= 1'b0;
      clken_q  <= 1'b0;
      vs_q2    <= 1'b0;
      href_q2  <= 1'b0;
      clken_q2 <= 1'b0;
      bit_q    <= 1'b0;
      col_q    <= {COL_W{1'b0}};
      ovf_q    <= 1'b0;
      row_q    <= 2'd0;
      w0_q     <= 3'd0;
      w1_q     <= 3'd0;
      w2_q     <= 3'd0;
    end else begin
      vs_q     <= per_frame_vsync;
      href_q   <= per_frame_href;
      clken_q  <= per_frame_clken;
      vs_q2    <= vs_q;
      href_q2  <= href_q;
      clken_q2 <= clken_q;
      bit_q    <= bit_d;
      col_q    <= col_d;
      ovf_q    <= ovf_d;
      row_q    <= row_d;
      w0_q     <= w0_d;
      w1_q     <= w1_d;
      w2_q     <= w2_d;
    end
  end

  // Filtering only starts on a full frame after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_FRAME;
    end else begin
      case (state_q)
        WAIT_FRAME: state_q <= vs_rise_s ? ACTIVE : WAIT_FRAME;
        ACTIVE:     state_q <= ACTIVE;
        default:    state_q <= WAIT_FRAME;
      endcase
    end
  end

  assign post_frame_vsync = vs_q2;
  assign post_frame_href  = href_q2;
  assign post_frame_clken = clken_q2;
  assign post_img_Bit     = bit_q;

endmodule

// File: tb/tb_vip_bin_morph_3x3.sv
// Directed bench: a dilate and an erode instance share one 8x8 stimulus stream.
module tb_vip_bin_morph_3x3;

  localparam int W = 8;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vs = 1'b0, href = 1'b0, clken = 1'b0, bitin = 1'b0;
  logic [1:0] pvs, phref, pclk, pbit;

  vip_bin_morph_3x3 #(.IMG_WIDTH(W), .MODE(0)) dut_dil (
    .clk(clk), .rst(rst),
    .per_frame_vsync(vs), .per_frame_href(href), .per_frame_clken(clken), .per_img_Bit(bitin),
    .post_frame_vsync(pvs[0]), .post_frame_href(phref[0]), .post_frame_clken(pclk[0]),
    .post_img_Bit(pbit[0])
  );

  vip_bin_morph_3x3 #(.IMG_WIDTH(W), .MODE(1)) dut_ero (
    .clk(clk), .rst(rst),
    .per_frame_vsync(vs), .per_frame_href(href), .per_frame_clken(clken), .per_img_Bit(bitin),
    .post_frame_vsync(pvs[1]), .post_frame_href(phref[1]), .post_frame_clken(pclk[1]),
    .post_img_Bit(pbit[1])
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  logic [7:0] img_in [H];
  logic [7:0] cap0 [H];
  logic [7:0] cap1 [H];
  logic [7:0] exp_img [H];
  int         orow = -1, ocol = 0, ocnt = 0;
  int         lat_err = 0, quiet_err = 0;
  bit         quiet_on = 1'b0;
  logic [5:0] hist1 = 6'd0, hist2 = 6'd0;
  bit         rh1 = 1'b0, rh2 = 1'b0;
  logic       pvs_prev = 1'b0, phref_prev = 1'b0;

  function automatic logic [7:0] rect_row(input int r, input int r0, input int r1,
                                          input int c0, input int c1);
    logic [7:0] v;
    v = 8'd0;
    for (int c = 0; c < W; c++) begin
      if (r >= r0 && r <= r1 && c >= c0 && c <= c1) v[c] = 1'b1;
    end
    return v;
  endfunction

  // Output monitor: reset response, 2-clk qualifier latency, quiet window, image capture.
  always @(negedge clk) begin
    if (rh1) begin
      check_eq("post_after_rst", 32'({pvs, phref, pclk, pbit}), 32'd0);
      quiet_on = 1'b1;
    end else if (!rh2) begin
      if ({pvs, phref, pclk} !== hist2) lat_err++;
    end
    if (quiet_on) begin
      if (vs) quiet_on = 1'b0;
      else if (pbit[0] !== 1'b0) quiet_err++;
    end
    hist2 = hist1;
    hist1 = {vs, vs, href, href, clken, clken};
    rh2   = rh1;
    rh1   = rst;
    if (pvs[0] && !pvs_prev) begin
      orow = -1;
      ocnt = 0;
    end
    if (phref[0] && !phref_prev) begin
      orow++;
      ocol = 0;
    end
    if (phref[0] && pclk[0]) begin
      if (orow >= 0 && orow < H && ocol < W) begin
        cap0[orow][ocol] = pbit[0];
        cap1[orow][ocol] = pbit[1];
        ocnt++;
      end
      ocol++;
    end
    pvs_prev   = pvs[0];
    phref_prev = phref[0];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_frame(input bit gaps, input int rst_row);
    int n;
    int c;
    for (int r = 0; r < H; r++) begin
      cap0[r] = 8'h5A;
      cap1[r] = 8'h5A;
    end
    n = gaps ? 2 * W : W;
    tick();
    vs = 1'b1;
    repeat (10) tick();
    vs = 1'b0;
    repeat (6) tick();
    for (int r = 0; r < H; r++) begin
      for (int i = 0; i < n; i++) begin
        tick();
        c     = gaps ? i / 2 : i;
        href  = 1'b1;
        clken = gaps ? (i % 2 == 0) : 1'b1;
        bitin = clken ? img_in[r][c] : 1'b1;
        rst   = (r == rst_row) && (i == 3);
      end
      tick();
      href  = 1'b0;
      clken = 1'b0;
      bitin = 1'b0;
      rst   = 1'b0;
      repeat (3) tick();
    end
    repeat (5) tick();
  endtask

  task automatic check_frame(input string tag, input bit use_ero);
    for (int r = 0; r < H; r++) begin
      check_eq($sformatf("%s_row%0d", tag, r), 32'(use_ero ? cap1[r] : cap0[r]), 32'(exp_img[r]));
    end
    check_eq({tag, "_pixcount"}, 32'(ocnt), 32'(W * H));
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_eq("idle_vsync", 32'(pvs), 32'd0);
    check_eq("idle_href", 32'(phref), 32'd0);
    check_eq("idle_clken", 32'(pclk), 32'd0);
    check_eq("idle_bit", 32'(pbit), 32'd0);

    // Single dot at (3,3) dilates to input-time rows 3..5, cols 3..5.
    for (int r = 0; r < H; r++) begin
      img_in[r]  = rect_row(r, 3, 3, 3, 3);
      exp_img[r] = rect_row(r, 3, 5, 3, 5);
    end
    drive_frame(1'b0, -1);
    check_frame("dot", 1'b0);
    drive_frame(1'b1, -1);
    check_frame("dot_gaps", 1'b0);

    // Hole at (4,4) eroded to zeros at rows 4..6, cols 4..6; borders stay 1.
    for (int r = 0; r < H; r++) begin
      img_in[r]  = ~rect_row(r, 4, 4, 4, 4);
      exp_img[r] = ~rect_row(r, 4, 6, 4, 6);
    end
    drive_frame(1'b0, -1);
    check_frame("erode_hole", 1'b1);

    // All-ones frame followed by an all-zeros frame: nothing leaks forward.
    for (int r = 0; r < H; r++) begin
      img_in[r]  = 8'hFF;
      exp_img[r] = 8'h00;
    end
    drive_frame(1'b0, -1);
    for (int r = 0; r < H; r++) img_in[r] = 8'h00;
    drive_frame(1'b0, -1);
    check_frame("isolation", 1'b0);

    // (2,0) and (1,7): (2,0) hits input-time cols 0..2 rows 2..4, (1,7) only col 7 rows 1..3.
    for (int r = 0; r < H; r++) begin
      img_in[r]  = rect_row(r, 2, 2, 0, 0) | rect_row(r, 1, 1, 7, 7);
      exp_img[r] = rect_row(r, 2, 4, 0, 2) | rect_row(r, 1, 3, 7, 7);
    end
    drive_frame(1'b0, -1);
    check_frame("no_wrap", 1'b0);

    // Reset during row 4 of an all-ones frame, then a clean all-ones frame.
    for (int r = 0; r < H; r++) begin
      img_in[r]  = 8'hFF;
      exp_img[r] = 8'hFF;
    end
    drive_frame(1'b0, 4);
    check_eq("quiet_before_vsync_live", 32'(quiet_on), 32'd1);
    drive_frame(1'b0, -1);
    check_eq("quiet_after_rst", 32'(quiet_err), 32'd0);
    check_frame("recover", 1'b0);

    check_eq("qualifier_latency_errs", 32'(lat_err), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
